// File: rtl/rr_encoder_arbiter.sv
// Four-requester round-robin arbiter with a registered one-hot grant, an encoded index and a valid flag.
// Optional forced release after MAX_HOLD cycles of holding is enabled by defining ARB_HOLD_TIMEOUT_EN.
module rr_encoder_arbiter #(
   parameter int N_REQ = 4
`ifdef ARB_HOLD_TIMEOUT_EN
   ,
   parameter int MAX_HOLD = 8
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [N_REQ-1:0] gnt,
   output logic [1:0]       gnt_idx,
   output logic             gnt_valid,
   output logic             timeout
);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t           state_r, state_nxt_s;
   logic [N_REQ-1:0] gnt_r, gnt_nxt_s;
   logic [1:0]       idx_r, idx_nxt_s;
   logic             valid_r, valid_nxt_s;
   logic [1:0]       last_r, last_nxt_s;
   logic [2:0]       pick_s;
   logic             release_s, force_s, new_grant_s, grant_s, idle_s;

   // The scan begins one place after the last winner, so the previous owner ranks lowest.
   // Bit 2 of the result is the found flag. Bits 1:0 are the winning index.
   function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] r, input logic [1:0] last);
      logic [1:0] cand;
      logic [2:0] res;
      res = 3'b000;
      for (int k = 3; k >= 0; k--) begin
         cand = last + 2'(k) + 2'd1;
         if (r[cand]) begin
            res = {1'b1, cand};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

`ifdef ARB_HOLD_TIMEOUT_EN
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);
   logic [HOLD_W-1:0] hold_cnt_r;
   logic              timeout_r;

   // Forced release only fires when no other release reason is present.
   always_comb begin
      force_s = (hold_cnt_r == HOLD_W'(MAX_HOLD - 1)) && !done && req[idx_r];
   end

   // Hold counter: cleared on every new grant, increments while granted, saturates at MAX_HOLD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_r <= '0;
         timeout_r  <= 1'b0;
      end else begin
         timeout_r <= (state_r == GRANT) && force_s;
         if (new_grant_s) begin
            hold_cnt_r <= '0;
         end else if ((state_r == GRANT) && (hold_cnt_r != HOLD_W'(MAX_HOLD))) begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
         end else begin
            hold_cnt_r <= hold_cnt_r;
         end
      end
   end

   assign timeout = timeout_r;
`else
   // Without the timeout feature there is no forced release.
   always_comb begin
      force_s = 1'b0;
   end

   assign timeout = 1'b0;
`endif

   // Next-state and next-grant logic. On release, the arbiter re-arbitrates in the same edge.
   always_comb begin
      pick_s      = rr_pick(req, last_r);
      release_s   = done || !req[idx_r] || force_s;
      grant_s     = 1'b0;
      idle_s      = 1'b0;
      new_grant_s = 1'b0;
      state_nxt_s = state_r;
      gnt_nxt_s   = gnt_r;
      idx_nxt_s   = idx_r;
      valid_nxt_s = valid_r;
      last_nxt_s  = last_r;
      case (state_r)
         IDLE: begin
            if (pick_s[2]) begin
               grant_s = 1'b1;
            end else begin
               idle_s = 1'b1;
            end
         end
         GRANT: begin
            if (release_s && pick_s[2]) begin
               grant_s = 1'b1;
            end else if (release_s) begin
               idle_s = 1'b1;
            end else begin
               grant_s = 1'b0;
            end
         end
         default: begin
            idle_s = 1'b1;
         end
      endcase
      if (grant_s) begin
         new_grant_s = 1'b1;
         state_nxt_s = GRANT;
         gnt_nxt_s   = N_REQ'(4'b0001 << pick_s[1:0]);
         idx_nxt_s   = pick_s[1:0];
         valid_nxt_s = 1'b1;
         last_nxt_s  = pick_s[1:0];
      end else if (idle_s) begin
         state_nxt_s = IDLE;
         gnt_nxt_s   = '0;
         idx_nxt_s   = 2'b00;
         valid_nxt_s = 1'b0;
      end else begin
         state_nxt_s = state_r;
      end
   end

   // State and output registers. After reset, req[0] has the highest priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         gnt_r   <= '0;
         idx_r   <= 2'b00;
         valid_r <= 1'b0;
         last_r  <= 2'd3;
      end else begin
         state_r <= state_nxt_s;
         gnt_r   <= gnt_nxt_s;
         idx_r   <= idx_nxt_s;
         valid_r <= valid_nxt_s;
         last_r  <= last_nxt_s;
      end
   end

   assign gnt       = gnt_r;
   assign gnt_idx   = idx_r;
   assign gnt_valid = valid_r;

endmodule
